spi_master: RTL and testbench

//  Byte-oriented SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first, SSEL active low.

---
 rtl/spi_master.sv | 251 +++++++++++++++++++++++++
 tb/tb_spi_master.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Byte-oriented SPI initiator, mode 0, MSB first, active-low select.
// Multi-byte messages keep SSEL low between bytes; every pin and status output is a flop.

module spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_GAP   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  tx_data,
  input  logic        last,
  input  logic        abort,
  output logic        ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic [15:0] byte_cnt,
  output logic        SCK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        SSEL
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LO    = 3'd2,
    HI    = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  localparam logic [15:0] DIV_END   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_END = 16'(CS_SETUP - 1);
  localparam logic [15:0] GAP_END   = 16'(CS_GAP - 1);

  state_t      state_r, state_s;
  logic [15:0] div_r, div_s;
  logic [2:0]  bit_r, bit_s;
  logic [7:0]  tx_r, tx_s;
  logic [7:0]  rx_sh_r, rx_sh_s;
  logic        last_r, last_s;
  logic        sck_r, sck_s;
  logic        mosi_r, mosi_s;
  logic        ssel_r, ssel_s;
  logic        ready_r, ready_s;
  logic [7:0]  rx_data_r, rx_data_s;
  logic        rx_valid_r, rx_valid_s;
  logic [15:0] byte_cnt_r, byte_cnt_s;
  logic        accept_s;
  logic        abortable_s;

  assign accept_s    = start & ready_r & ~abort;
  assign abortable_s = (state_r != IDLE) && (state_r != GAP);

  // Next-state and next-output logic; abort overrides every active phase
  always_comb begin
    state_s    = state_r;
    div_s      = div_r + 16'd1;
    bit_s      = bit_r;
    tx_s       = tx_r;
    rx_sh_s    = rx_sh_r;
    last_s     = last_r;
    sck_s      = sck_r;
    mosi_s     = mosi_r;
    ssel_s     = ssel_r;
    ready_s    = ready_r;
    rx_data_s  = rx_data_r;
    rx_valid_s = 1'b0;
    byte_cnt_s = byte_cnt_r;

    if (abort && abortable_s) begin
      state_s = GAP;
      div_s   = 16'd0;
      sck_s   = 1'b0;
      ssel_s  = 1'b1;
      mosi_s  = 1'b0;
      ready_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          div_s = 16'd0;
          if (accept_s) begin
            tx_s       = tx_data;
            last_s     = last;
            bit_s      = 3'd0;
            byte_cnt_s = 16'd0;
            ssel_s     = 1'b0;
            mosi_s     = tx_data[7];
            ready_s    = 1'b0;
            state_s    = SETUP;
          end else begin
            ready_s = 1'b1;
          end
        end
        SETUP: begin
          if (div_r == SETUP_END) begin
            div_s   = 16'd0;
            state_s = LO;
          end else begin
            sck_s = 1'b0;
          end
        end
        LO: begin
          if (div_r == DIV_END) begin
            sck_s   = 1'b1;
            rx_sh_s = {rx_sh_r[6:0], MISO};
            div_s   = 16'd0;
            state_s = HI;
          end else begin
            sck_s = 1'b0;
          end
        end
        HI: begin
          if (div_r == DIV_END) begin
            sck_s = 1'b0;
            div_s = 16'd0;
            bit_s = bit_r + 3'd1;
            if (bit_r == 3'd7) begin
              rx_data_s  = rx_sh_r;
              rx_valid_s = 1'b1;
              byte_cnt_s = (byte_cnt_r == 16'hFFFF) ? byte_cnt_r : byte_cnt_r + 16'd1;
              if (last_r) begin
                ssel_s  = 1'b1;
                state_s = GAP;
              end else begin
                ready_s = 1'b1;
                state_s = HOLD;
              end
            end else begin
              // MOSI moves only on the falling SCK edge
              mosi_s  = tx_r[6];
              tx_s    = {tx_r[6:0], 1'b0};
              state_s = LO;
            end
          end else begin
            sck_s = 1'b1;
          end
        end
        HOLD: begin
          div_s = 16'd0;
          if (accept_s) begin
            tx_s    = tx_data;
            last_s  = last;
            bit_s   = 3'd0;
            mosi_s  = tx_data[7];
            ready_s = 1'b0;
            state_s = LO;
          end else begin
            ready_s = 1'b1;
          end
        end
        GAP: begin
          if (div_r == GAP_END) begin
            div_s   = 16'd0;
            ready_s = 1'b1;
            state_s = IDLE;
          end else begin
            ready_s = 1'b0;
          end
        end
        default: begin
          state_s = IDLE;
          div_s   = 16'd0;
          sck_s   = 1'b0;
          ssel_s  = 1'b1;
          mosi_s  = 1'b0;
          ready_s = 1'b1;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      div_r      <= 16'd0;
      bit_r      <= 3'd0;
      tx_r       <= 8'd0;
      rx_sh_r    <= 8'd0;
      last_r     <= 1'b0;
      sck_r      <= 1'b0;
      mosi_r     <= 1'b0;
      ssel_r     <= 1'b1;
      ready_r    <= 1'b1;
      rx_data_r  <= 8'd0;
      rx_valid_r <= 1'b0;
      byte_cnt_r <= 16'd0;
    end else begin
      state_r    <= state_s;
      div_r      <= div_s;
      bit_r      <= bit_s;
      tx_r       <= tx_s;
      rx_sh_r    <= rx_sh_s;
      last_r     <= last_s;
      sck_r      <= sck_s;
      mosi_r     <= mosi_s;
      ssel_r     <= ssel_s;
      ready_r    <= ready_s;
      rx_data_r  <= rx_data_s;
      rx_valid_r <= rx_valid_s;
      byte_cnt_r <= byte_cnt_s;
    end
  end

  assign SCK      = sck_r;
  assign MOSI     = mosi_r;
  assign SSEL     = ssel_r;
  assign ready    = ready_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign byte_cnt = byte_cnt_r;

  spi_master_chk u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .sck      (sck_r),
    .mosi     (mosi_r),
    .ssel     (ssel_r),
    .ready    (ready_r),
    .rx_valid (rx_valid_r)
  );

endmodule

// Pin-level protocol properties of the initiator.
module spi_master_chk (
  input logic clk,
  input logic rst_n,
  input logic sck,
  input logic mosi,
  input logic ssel,
  input logic ready,
  input logic rx_valid
);

  ssel_edge_sck_low: assert property (@(posedge clk) disable iff (!rst_n)
    (ssel != $past(ssel)) |-> !sck);

  mosi_stable_sck_high: assert property (@(posedge clk) disable iff (!rst_n)
    sck |-> (mosi == $past(mosi)));

  ready_sck_low: assert property (@(posedge clk) disable iff (!rst_n)
    ready |-> !sck);

  rx_valid_sck_low: assert property (@(posedge clk) disable iff (!rst_n)
    rx_valid |-> !sck);

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master: a mode-0 slave model feeds MISO and captures MOSI,
// expected bytes and latencies come from the slave tables and the timing formulas.
`timescale 1ns/1ps

module tb_spi_master;

  localparam int CLK_DIV   = 2;
  localparam int CS_SETUP  = 2;
  localparam int CS_GAP    = 4;
  localparam int LAT_FIRST = CS_SETUP + 16 * CLK_DIV + 1;
  localparam int LAT_HOLD  = 16 * CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  tx_data = 8'd0;
  logic        last = 1'b0;
  logic        abort = 1'b0;
  logic        MISO = 1'b0;
  logic        ready, rx_valid, SCK, MOSI, SSEL;
  logic [7:0]  rx_data;
  logic [15:0] byte_cnt;

  int total = 0;
  int passed = 0;
  int cyc = 0;

  logic [7:0]  rxq[$];
  int          rxcq[$];
  logic [15:0] bcq[$];
  logic [7:0]  mosiq[$];
  logic [7:0]  slave_bytes [0:7];

  int   viol = 0, ssel_rises = 0, rises = 0, mbits = 0, sbit = 0, sbyte = 0;
  logic [7:0] msh = 8'd0;
  logic p_sck = 1'b0, p_ssel = 1'b1, p_mosi = 1'b0;

  spi_master #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .last(last),
    .abort(abort), .ready(ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .byte_cnt(byte_cnt), .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .SSEL(SSEL)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model, rx logger and pin protocol watcher, sampled 1ns after each rising edge
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      p_sck = 1'b0; p_ssel = 1'b1; p_mosi = 1'b0;
      mbits = 0; sbit = 0; sbyte = 0; rises = 0;
    end else begin
      if (rx_valid) begin
        rxq.push_back(rx_data);
        rxcq.push_back(cyc);
        bcq.push_back(byte_cnt);
      end
      if (SSEL !== p_ssel && SCK) viol++;
      if (SCK && MOSI !== p_mosi) viol++;
      if (SSEL && !p_ssel) ssel_rises++;
      if (SSEL) begin
        mbits = 0; sbit = 0; sbyte = 0; rises = 0;
      end else begin
        if (!p_sck && SCK) begin
          msh = {msh[6:0], MOSI};
          mbits++;
          rises++;
          if (mbits == 8) begin
            mosiq.push_back(msh);
            mbits = 0;
          end
        end
        if (p_sck && !SCK) begin
          if (sbit == 7) begin sbit = 0; sbyte++; end
          else sbit++;
        end
      end
      p_sck = SCK; p_ssel = SSEL; p_mosi = MOSI;
    end
    MISO = slave_bytes[sbyte[2:0]][7 - sbit];
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_byte(input logic [7:0] b, input logic l, output int t0);
    int k = 0;
    @(negedge clk);
    while (!ready && k < 400) begin @(negedge clk); k++; end
    start = 1'b1; tx_data = b; last = l; t0 = cyc;
    @(negedge clk);
    start = 1'b0; last = 1'b0;
  endtask

  task automatic wait_rx(input int n0, output bit ok);
    int k = 0;
    while (rxq.size() <= n0 && k < 400) begin @(negedge clk); k++; end
    ok = (rxq.size() > n0);
  endtask

  task automatic wait_ready(output int c);
    int k = 0;
    while (!ready && k < 400) begin @(negedge clk); k++; end
    c = cyc;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (SCK !== 1'b0) $display("FAIL reset_sck: got %b want 0", SCK); else passed++;
    total++; if (MOSI !== 1'b0) $display("FAIL reset_mosi: got %b want 0", MOSI); else passed++;
    total++; if (SSEL !== 1'b1) $display("FAIL reset_ssel: got %b want 1", SSEL); else passed++;
    total++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else passed++;
    total++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else passed++;
    total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else passed++;
    total++; if (byte_cnt !== 16'd0) $display("FAIL reset_byte_cnt: got %0d want 0", byte_cnt); else passed++;
    rst_n = 1'b1;
    cycles(2);
    total++; if (ready !== 1'b1 || SSEL !== 1'b1) $display("FAIL post_reset_idle: got ready=%b ssel=%b want 1/1", ready, SSEL); else passed++;
  endtask

  task automatic test_single();
    int t0, n0, m0, c;
    bit ok;
    slave_bytes[0] = 8'h3C;
    n0 = rxq.size(); m0 = mosiq.size();
    start_byte(8'hA5, 1'b1, t0);
    wait_rx(n0, ok);
    total++; if (!ok) $display("FAIL single_timeout: got no rx_valid want one"); else passed++;
    if (ok) begin
      total++; if (rxcq[n0] - t0 !== LAT_FIRST) $display("FAIL single_latency: got %0d want %0d", rxcq[n0] - t0, LAT_FIRST); else passed++;
      total++; if (rxq[n0] !== 8'h3C) $display("FAIL single_rx: got %h want 3c", rxq[n0]); else passed++;
      total++; if (bcq[n0] !== 16'd1) $display("FAIL single_cnt: got %0d want 1", bcq[n0]); else passed++;
      total++; if (mosiq.size() <= m0 || mosiq[m0] !== 8'hA5) $display("FAIL single_mosi: got %0d bytes want a5", mosiq.size() - m0); else passed++;
      @(negedge clk);
      total++; if (SSEL !== 1'b1) $display("FAIL single_ssel_high: got %b want 1", SSEL); else passed++;
      wait_ready(c);
      total++; if (c - rxcq[n0] !== CS_GAP) $display("FAIL single_gap: got %0d want %0d", c - rxcq[n0], CS_GAP); else passed++;
    end
  endtask

  task automatic test_random();
    int t0, n0, m0, c;
    bit ok;
    logic [7:0] tb, rb;
    for (int i = 0; i < 6; i++) begin
      tb = 8'($urandom); rb = 8'($urandom);
      slave_bytes[0] = rb;
      n0 = rxq.size(); m0 = mosiq.size();
      start_byte(tb, 1'b1, t0);
      wait_rx(n0, ok);
      total++; if (!ok || rxq[n0] !== rb) $display("FAIL rand_rx[%0d]: got %h want %h", i, ok ? rxq[n0] : 8'hxx, rb); else passed++;
      total++; if (mosiq.size() <= m0 || mosiq[m0] !== tb) $display("FAIL rand_mosi[%0d]: want %h", i, tb); else passed++;
      total++; if (!ok || rxcq[n0] - t0 !== LAT_FIRST) $display("FAIL rand_latency[%0d]: want %0d", i, LAT_FIRST); else passed++;
      wait_ready(c);
    end
  endtask

  task automatic test_multi();
    int t0, n0, m0, r0, c;
    bit ok;
    logic [7:0] tb [0:2];
    tb[0] = 8'h01; tb[1] = 8'h02; tb[2] = 8'h03;
    for (int i = 0; i < 3; i++) slave_bytes[i] = 8'($urandom);
    n0 = rxq.size(); m0 = mosiq.size(); r0 = ssel_rises;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        total++; if (ready !== 1'b1 || SSEL !== 1'b0) $display("FAIL multi_hold[%0d]: got ready=%b ssel=%b want 1/0", i, ready, SSEL); else passed++;
        cycles(4);
      end
      start_byte(tb[i], (i == 2) ? 1'b1 : 1'b0, t0);
      wait_rx(n0 + i, ok);
      total++; if (!ok || rxq[n0 + i] !== slave_bytes[i]) $display("FAIL multi_rx[%0d]: want %h", i, slave_bytes[i]); else passed++;
      total++; if (!ok || rxcq[n0 + i] - t0 !== ((i == 0) ? LAT_FIRST : LAT_HOLD)) $display("FAIL multi_latency[%0d]: got %0d", i, ok ? rxcq[n0 + i] - t0 : -1); else passed++;
      total++; if (!ok || bcq[n0 + i] !== 16'(i + 1)) $display("FAIL multi_cnt[%0d]: want %0d", i, i + 1); else passed++;
      total++; if (mosiq.size() <= m0 + i || mosiq[m0 + i] !== tb[i]) $display("FAIL multi_mosi[%0d]: want %h", i, tb[i]); else passed++;
    end
    total++; if (ssel_rises - r0 !== 1) $display("FAIL multi_ssel_continuous: got %0d rises want 1", ssel_rises - r0); else passed++;
    wait_ready(c);
    total++; if (byte_cnt !== 16'd3) $display("FAIL multi_cnt_hold: got %0d want 3", byte_cnt); else passed++;
  endtask

  task automatic test_busy_start();
    int t0, n0, m0, k;
    logic [7:0] tb, rb;
    tb = 8'($urandom); rb = 8'($urandom);
    slave_bytes[0] = rb;
    n0 = rxq.size(); m0 = mosiq.size();
    start_byte(tb, 1'b1, t0);
    k = 0;
    while (!ready && k < 200) begin
      start = (($urandom & 32'd1) != 32'd0);
      tx_data = 8'($urandom);
      last = (($urandom & 32'd1) != 32'd0);
      @(negedge clk);
      k++;
    end
    start = 1'b0; last = 1'b0;
    cycles(6);
    total++; if (rxq.size() !== n0 + 1) $display("FAIL busy_count: got %0d want 1 pulse", rxq.size() - n0); else passed++;
    total++; if (rxq.size() <= n0 || rxq[n0] !== rb) $display("FAIL busy_rx: want %h", rb); else passed++;
    total++; if (mosiq.size() <= m0 || mosiq[m0] !== tb) $display("FAIL busy_mosi: want %h", tb); else passed++;
    total++; if (SSEL !== 1'b1 || ready !== 1'b1) $display("FAIL busy_idle: got ssel=%b ready=%b want 1/1", SSEL, ready); else passed++;
  endtask

  task automatic test_abort();
    int t0, n0, k, t, c;
    bit ok;
    logic [7:0] rb;
    slave_bytes[0] = 8'($urandom);
    n0 = rxq.size();
    start_byte(8'($urandom), 1'b1, t0);
    k = 0;
    while (!(SCK && rises == 5) && k < 400) begin @(negedge clk); k++; end
    total++; if (!(SCK && rises == 5)) $display("FAIL abort_reach_bit5: got rises=%0d want 5", rises); else passed++;
    abort = 1'b1; t = cyc;
    @(negedge clk);
    abort = 1'b0;
    total++; if ({SCK, SSEL, MOSI} !== 3'b010) $display("FAIL abort_pins: got sck/ssel/mosi=%b want 010", {SCK, SSEL, MOSI}); else passed++;
    wait_ready(c);
    total++; if (c - t !== CS_GAP + 1) $display("FAIL abort_gap: got %0d want %0d", c - t, CS_GAP + 1); else passed++;
    total++; if (rxq.size() !== n0) $display("FAIL abort_no_rx: got %0d pulses want 0", rxq.size() - n0); else passed++;
    total++; if (byte_cnt !== 16'd0) $display("FAIL abort_cnt: got %0d want 0", byte_cnt); else passed++;
    rb = 8'($urandom);
    slave_bytes[0] = rb;
    start_byte(8'($urandom), 1'b1, t0);
    wait_rx(n0, ok);
    total++; if (!ok || rxq[n0] !== rb || rxcq[n0] - t0 !== LAT_FIRST) $display("FAIL abort_recover: want rx %h at %0d", rb, LAT_FIRST); else passed++;
    wait_ready(c);
  endtask

  task automatic test_abort_start();
    int t0, n0, c, t;
    bit ok;
    @(negedge clk);
    start = 1'b1; abort = 1'b1; tx_data = 8'($urandom);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    cycles(4);
    total++; if (SSEL !== 1'b1 || ready !== 1'b1) $display("FAIL idle_abort_start: got ssel=%b ready=%b want 1/1", SSEL, ready); else passed++;
    slave_bytes[0] = 8'($urandom);
    n0 = rxq.size();
    start_byte(8'($urandom), 1'b0, t0);
    wait_rx(n0, ok);
    @(negedge clk);
    start = 1'b1; abort = 1'b1; tx_data = 8'($urandom); t = cyc;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    total++; if (SSEL !== 1'b1 || ready !== 1'b0) $display("FAIL hold_abort_start: got ssel=%b ready=%b want 1/0", SSEL, ready); else passed++;
    wait_ready(c);
    total++; if (c - t !== CS_GAP + 1) $display("FAIL hold_abort_gap: got %0d want %0d", c - t, CS_GAP + 1); else passed++;
    total++; if (byte_cnt !== 16'd1 || rxq.size() !== n0 + 1) $display("FAIL hold_abort_cnt: got %0d want 1", byte_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    int t0, n0, m0, k, c;
    bit ok;
    logic [7:0] rb;
    slave_bytes[0] = 8'($urandom);
    start_byte(8'($urandom), 1'b1, t0);
    k = 0;
    while (rises < 3 && k < 400) begin @(negedge clk); k++; end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({SCK, MOSI, SSEL, ready, rx_valid} !== 5'b00110) $display("FAIL midreset_pins: got %b want 00110", {SCK, MOSI, SSEL, ready, rx_valid}); else passed++;
    total++; if (rx_data !== 8'h00 || byte_cnt !== 16'd0) $display("FAIL midreset_regs: got rx=%h cnt=%0d want 00/0", rx_data, byte_cnt); else passed++;
    cycles(2);
    rst_n = 1'b1;
    rb = 8'($urandom);
    slave_bytes[0] = rb;
    n0 = rxq.size(); m0 = mosiq.size();
    start_byte(8'hFF, 1'b1, t0);
    wait_rx(n0, ok);
    total++; if (!ok || rxq[n0] !== rb) $display("FAIL midreset_rx: want %h", rb); else passed++;
    total++; if (mosiq.size() <= m0 || mosiq[m0] !== 8'hFF) $display("FAIL midreset_mosi: want ff"); else passed++;
    total++; if (!ok || rxcq[n0] - t0 !== LAT_FIRST || bcq[n0] !== 16'd1) $display("FAIL midreset_timing: want latency %0d cnt 1", LAT_FIRST); else passed++;
    wait_ready(c);
  endtask

  task automatic test_protocol();
    total++; if (viol !== 0) $display("FAIL protocol: got %0d violations want 0", viol); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) slave_bytes[i] = 8'h00;
    cycles(3);
    test_reset();
    test_single();
    test_random();
    test_multi();
    test_busy_start();
    test_abort();
    test_abort_start();
    test_reset_mid();
    test_protocol();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1);
  end

endmodule
